// File: rtl/rnm_ramp_stim_gen.sv
// Clocked real-number-model stimulus generator: ramps NUM_CH channels between
// the rails for a programmed number of rise/fall cycles, with hysteretic digitisation.
module rnm_ramp_stim_gen #(
    parameter real VDD         = 1.8,
    parameter real VSS         = 0.0,
    parameter int  NUM_CH      = 4,
    parameter int  NUM_STEPS   = 10,
    parameter int  HOLD_CYCLES = 5,
    parameter int  CYC_W       = 8,
    parameter real VTH_HI      = 1.0,
    parameter real VTH_LO      = 0.8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [CYC_W-1:0]  num_cycles_i,
    input  logic [NUM_CH-1:0] inv_mask_i,
    output logic              busy_o,
    output logic              done_o,
    output real               vout_o [NUM_CH],
    output logic [NUM_CH-1:0] dig_o
);

    localparam int  IDX_W  = $clog2(NUM_STEPS + 1);
    localparam int  HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam real STEP   = (VDD - VSS) / NUM_STEPS;

    typedef enum logic [2:0] {
        IDLE,
        RISE,
        HIGH,
        FALL,
        LOW,
        DONE
    } state_t;

    state_t              state_q;
    logic [IDX_W-1:0]    idx_q;
    logic [HOLD_W-1:0]   hold_q;
    logic [CYC_W-1:0]    cyc_q;
    logic [CYC_W-1:0]    ncyc_q;
    logic [NUM_CH-1:0]   inv_q;
    logic                busy_q;
    logic                done_q;
    logic [NUM_CH-1:0]   dig_q;
    logic [NUM_CH-1:0]   dig_d;
    logic [CYC_W-1:0]    last_cyc;
    real                 base;

    // A programmed count of zero still runs one full cycle.
    assign last_cyc = (ncyc_q == '0) ? '0 : ncyc_q - CYC_W'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
            hold_q  <= '0;
            cyc_q   <= '0;
            ncyc_q  <= '0;
            inv_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (busy_q && abort_i) begin
                state_q <= IDLE;
                idx_q   <= '0;
                hold_q  <= '0;
                cyc_q   <= '0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_i && !abort_i) begin
                            inv_q   <= inv_mask_i;
                            ncyc_q  <= num_cycles_i;
                            idx_q   <= '0;
                            hold_q  <= '0;
                            cyc_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= RISE;
                        end
                    end
                    RISE: begin
                        if (idx_q == IDX_W'(NUM_STEPS)) begin
                            hold_q  <= '0;
                            state_q <= HIGH;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                    HIGH: begin
                        if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
                            state_q <= FALL;
                        end else begin
                            hold_q <= hold_q + HOLD_W'(1);
                        end
                    end
                    FALL: begin
                        if (idx_q == '0) begin
                            hold_q  <= '0;
                            state_q <= LOW;
                        end else begin
                            idx_q <= idx_q - IDX_W'(1);
                        end
                    end
                    LOW: begin
                        if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
                            hold_q <= '0;
                            if (cyc_q == last_cyc) begin
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= DONE;
                            end else begin
                                cyc_q   <= cyc_q + CYC_W'(1);
                                state_q <= RISE;
                            end
                        end else begin
                            hold_q <= hold_q + HOLD_W'(1);
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Voltage is recomputed from idx every cycle, so repeated ramps never drift.
    always_comb begin
        base = VSS + real'(idx_q) * STEP;
        for (int c = 0; c < NUM_CH; c++) begin
            vout_o[c] = inv_q[c] ? (VDD + VSS - base) : base;
        end
    end

    always_comb begin
        dig_d = dig_q;
        for (int c = 0; c < NUM_CH; c++) begin
            if (vout_o[c] > VTH_HI) begin
                dig_d[c] = 1'b1;
            end else if (vout_o[c] < VTH_LO) begin
                dig_d[c] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dig_q <= '0;
        end else begin
            dig_q <= dig_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign dig_o  = dig_q;

endmodule

// File: tb/tb_rnm_ramp_stim_gen.sv
// Directed testbench for rnm_ramp_stim_gen with hand-derived ramp voltages
// (default parameters: 0.18 V steps, 32-clock period).
module tb_rnm_ramp_stim_gen;

    localparam int  NUM_CH = 4;
    localparam real TOL    = 1.0e-9;

    logic        clk = 1'b0;
    logic        rstN;
    logic        start;
    logic        abort;
    logic [7:0]  numCycles;
    logic [3:0]  invMask;
    logic        busy;
    logic        done;
    real         vout [NUM_CH];
    logic [3:0]  dig;

    int vecCount = 0;
    int errCount = 0;

    rnm_ramp_stim_gen dut (
        .clk_i        (clk),
        .rst_ni       (rstN),
        .start_i      (start),
        .abort_i      (abort),
        .num_cycles_i (numCycles),
        .inv_mask_i   (invMask),
        .busy_o       (busy),
        .done_o       (done),
        .vout_o       (vout),
        .dig_o        (dig)
    );

    always #5 clk = ~clk;

    function automatic real rabs(input real x);
        return (x < 0.0) ? -x : x;
    endfunction

    // Expected non-inverted voltage at position p within a 32-clock period.
    function automatic real expBase(input int p);
        if (p <= 10) return p * 0.18;
        else if (p <= 15) return 1.8;
        else if (p <= 26) return (26 - p) * 0.18;
        else return 0.0;
    endfunction

    task automatic test_reset();
        rstN = 1'b0;
        #12;
        vecCount++;
        if (busy !== 1'b0) begin errCount++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        vecCount++;
        if (done !== 1'b0) begin errCount++; $display("[TB] FAIL reset_done got %b want 0", done); end
        vecCount++;
        if (dig !== 4'b0000) begin errCount++; $display("[TB] FAIL reset_dig got %b want 0000", dig); end
        for (int c = 0; c < NUM_CH; c++) begin
            vecCount++;
            if (rabs(vout[c]) > TOL) begin
                errCount++; $display("[TB] FAIL reset_vout%0d got %f want 0.0", c, vout[c]);
            end
        end
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_run();
        real        ev;
        logic [3:0] expDig;
        numCycles = 8'd1;
        invMask   = 4'b0000;
        start     = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        expDig = 4'b0000;
        for (int k = 0; k < 32; k++) begin
            // Mid-run start/mask/count changes must not disturb the run.
            if (k == 5) begin start = 1'b1; invMask = 4'hF; numCycles = 8'd5; end
            if (k == 6) start = 1'b0;
            ev = expBase(k);
            vecCount++;
            if (busy !== 1'b1) begin errCount++; $display("[TB] FAIL run_busy k=%0d got %b want 1", k, busy); end
            vecCount++;
            if (done !== 1'b0) begin errCount++; $display("[TB] FAIL run_done k=%0d got %b want 0", k, done); end
            for (int c = 0; c < NUM_CH; c++) begin
                vecCount++;
                if (rabs(vout[c] - ev) > TOL) begin
                    errCount++; $display("[TB] FAIL run_vout%0d k=%0d got %f want %f", c, k, vout[c], ev);
                end
            end
            vecCount++;
            if (dig !== expDig) begin errCount++; $display("[TB] FAIL run_dig k=%0d got %b want %b", k, dig, expDig); end
            for (int c = 0; c < NUM_CH; c++) begin
                if (ev > 1.0) expDig[c] = 1'b1;
                else if (ev < 0.8) expDig[c] = 1'b0;
            end
            @(negedge clk);
        end
        vecCount++;
        if (done !== 1'b1) begin errCount++; $display("[TB] FAIL run_done_pulse got %b want 1", done); end
        vecCount++;
        if (busy !== 1'b0) begin errCount++; $display("[TB] FAIL run_busy_end got %b want 0", busy); end
        vecCount++;
        if (rabs(vout[0]) > TOL) begin errCount++; $display("[TB] FAIL run_vout_end got %f want 0.0", vout[0]); end
        @(negedge clk);
        vecCount++;
        if (done !== 1'b0) begin errCount++; $display("[TB] FAIL run_done_once got %b want 0", done); end
        invMask   = 4'b0000;
        numCycles = 8'd1;
    endtask

    task automatic test_inverted();
        real        ev;
        real        ec [NUM_CH];
        logic [3:0] expDig;
        numCycles = 8'd3;
        invMask   = 4'b0101;
        start     = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        invMask = 4'b0000;
        expDig  = 4'b0000;
        for (int k = 0; k < 96; k++) begin
            ev = expBase(k % 32);
            for (int c = 0; c < NUM_CH; c++) ec[c] = (c % 2 == 0) ? 1.8 - ev : ev;
            vecCount++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                errCount++; $display("[TB] FAIL inv_status k=%0d got busy=%b done=%b want busy=1 done=0", k, busy, done);
            end
            for (int c = 0; c < NUM_CH; c++) begin
                vecCount++;
                if (rabs(vout[c] - ec[c]) > TOL) begin
                    errCount++; $display("[TB] FAIL inv_vout%0d k=%0d got %f want %f", c, k, vout[c], ec[c]);
                end
            end
            vecCount++;
            if (rabs(vout[0] + vout[1] - 1.8) > TOL || rabs(vout[2] + vout[3] - 1.8) > TOL) begin
                errCount++; $display("[TB] FAIL inv_sum k=%0d got %f/%f want 1.8", k, vout[0] + vout[1], vout[2] + vout[3]);
            end
            vecCount++;
            if (dig !== expDig) begin errCount++; $display("[TB] FAIL inv_dig k=%0d got %b want %b", k, dig, expDig); end
            for (int c = 0; c < NUM_CH; c++) begin
                if (ec[c] > 1.0) expDig[c] = 1'b1;
                else if (ec[c] < 0.8) expDig[c] = 1'b0;
            end
            @(negedge clk);
        end
        vecCount++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errCount++; $display("[TB] FAIL inv_done got done=%b busy=%b want done=1 busy=0", done, busy);
        end
        @(negedge clk);
    endtask

    task automatic test_zero_cycles();
        numCycles = 8'd0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 32; k++) begin
            vecCount++;
            if (done !== 1'b0 || busy !== 1'b1) begin
                errCount++; $display("[TB] FAIL zero_run k=%0d got done=%b busy=%b want done=0 busy=1", k, done, busy);
            end
            @(negedge clk);
        end
        vecCount++;
        if (done !== 1'b1) begin errCount++; $display("[TB] FAIL zero_done got %b want 1", done); end
        @(negedge clk);
        vecCount++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errCount++; $display("[TB] FAIL zero_idle got busy=%b done=%b want 0/0", busy, done);
        end
        numCycles = 8'd1;
    endtask

    task automatic test_abort();
        numCycles = 8'd2;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // k = 32 + 11 + 2 lands in HIGH of the second cycle.
        repeat (45) @(negedge clk);
        vecCount++;
        if (rabs(vout[0] - 1.8) > TOL) begin errCount++; $display("[TB] FAIL abort_pre_vout got %f want 1.8", vout[0]); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        vecCount++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errCount++; $display("[TB] FAIL abort_status got busy=%b done=%b want 0/0", busy, done);
        end
        vecCount++;
        if (rabs(vout[0]) > TOL) begin errCount++; $display("[TB] FAIL abort_vout got %f want 0.0", vout[0]); end
        vecCount++;
        if (dig[0] !== 1'b1) begin errCount++; $display("[TB] FAIL abort_dig_hold got %b want 1", dig[0]); end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vecCount++;
        if (dig[0] !== 1'b0) begin errCount++; $display("[TB] FAIL abort_dig_clear got %b want 0", dig[0]); end
        vecCount++;
        if (busy !== 1'b1 || done !== 1'b0 || rabs(vout[0]) > TOL) begin
            errCount++; $display("[TB] FAIL restart_k0 got busy=%b done=%b vout=%f want 1/0/0.0", busy, done, vout[0]);
        end
        @(negedge clk);
        vecCount++;
        if (rabs(vout[0] - 0.18) > TOL) begin errCount++; $display("[TB] FAIL restart_k1 got %f want 0.18", vout[0]); end
        // Fresh two-cycle run ends after 64 busy clocks.
        repeat (63) @(negedge clk);
        vecCount++;
        if (done !== 1'b1) begin errCount++; $display("[TB] FAIL restart_done got %b want 1", done); end
        @(negedge clk);
        numCycles = 8'd1;
    endtask

    task automatic test_reset_midrun();
        numCycles = 8'd1;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        vecCount++;
        if (rabs(vout[0] - 1.26) > TOL || dig[0] !== 1'b1) begin
            errCount++; $display("[TB] FAIL fall_idx7 got vout=%f dig=%b want 1.26/1", vout[0], dig[0]);
        end
        #1 rstN = 1'b0;
        #1;
        vecCount++;
        if (rabs(vout[0]) > TOL || busy !== 1'b0 || dig !== 4'b0000 || done !== 1'b0) begin
            errCount++; $display("[TB] FAIL async_reset got vout=%f busy=%b dig=%b done=%b want 0.0/0/0000/0", vout[0], busy, dig, done);
        end
        @(negedge clk);
        rstN  = 1'b1;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        vecCount++;
        if (busy !== 1'b0 || rabs(vout[0]) > TOL) begin
            errCount++; $display("[TB] FAIL start_abort got busy=%b vout=%f want 0/0.0", busy, vout[0]);
        end
        @(negedge clk);
        vecCount++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errCount++; $display("[TB] FAIL start_abort_idle got busy=%b done=%b want 0/0", busy, done);
        end
    endtask

    initial begin
        rstN      = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        numCycles = 8'd1;
        invMask   = 4'b0000;
        test_reset();
        test_single_run();
        test_inverted();
        test_zero_cycles();
        test_abort();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule

// File: doc/rnm_ramp_stim_gen.md
Name: rnm_ramp_stim_gen

Overview:
- Clocked, parametrised real-number-model (RNM) stimulus generator for analog-behavioural DUTs such as the RNM inverter.
- Replaces hand-written rise/fall tasks with a synthesizable-style sequencer.
- Drives NUM_CH real-valued ramp/hold waveforms, with per-channel polarity, for a programmed number of cycles.
- Provides a hysteretic digitised copy of each channel for checkers.

Parameters:
- VDD, 1.8, high rail in volts (real)
- VSS, 0.0, low rail in volts (real)
- NUM_CH, 4, number of output channels (>=1)
- NUM_STEPS, 10, ramp steps between rails (>=1)
- HOLD_CYCLES, 5, clock cycles held at each rail (>=1)
- CYC_W, 8, width of the cycle-count input
- VTH_HI, 1.0, digitiser rising threshold in volts (real, > VTH_LO)
- VTH_LO, 0.8, digitiser falling threshold in volts (real)

Ports:
- clk  input  1  sequencer clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to begin a run
- abort  input  1  terminate run
- num_cycles  input  CYC_W  rise/fall cycles per run; 0 is treated as 1
- inv_mask  input  NUM_CH  per-channel polarity (1 = inverted waveform)
- busy  output  1  run in progress
- done  output  1  one-cycle pulse at normal completion
- vout  output  real[NUM_CH]  channel voltages
- dig  output  NUM_CH  registered hysteretic digitisation of vout

Behaviour:
- Single clock clk; asynchronous active-low reset rst_n.
- Reset state:
  - state = IDLE, idx = 0, hold_cnt = 0, cyc_cnt = 0.
  - busy = 0, done = 0, dig = 0, latched inv_mask = 0.
  - Hence vout = VSS on all channels.
- Voltage computation:
  - STEP = (VDD-VSS)/NUM_STEPS, computed in real.
  - Base voltage = VSS + idx*STEP, a function of the registered idx only. No accumulation, so there is no rounding drift.
  - vout[c] = base when inv_mask_q[c] = 0, else VDD+VSS-base.
- FSM states: IDLE, RISE, HIGH, FALL, LOW, DONE.
  - IDLE:
    - start=1 and abort=0: latch inv_mask and num_cycles; idx=0, cyc_cnt=0; go to RISE.
    - start with abort in the same cycle: abort wins, stay in IDLE.
  - RISE:
    - idx < NUM_STEPS: idx++.
    - idx == NUM_STEPS: go to HIGH, hold_cnt=0.
    - Occupies NUM_STEPS+1 cycles.
  - HIGH: hold_cnt++; at hold_cnt == HOLD_CYCLES-1, go to FALL.
  - FALL: mirror of RISE; idx-- down to 0, then LOW with hold_cnt=0.
  - LOW: hold HOLD_CYCLES cycles, then:
    - cyc_cnt == max(num_cycles_q,1)-1: go to DONE.
    - otherwise cyc_cnt++ and go to RISE.
  - DONE: done=1 for exactly this cycle, then IDLE.
- busy = 1 in RISE/HIGH/FALL/LOW, 0 in IDLE/DONE. start is ignored while busy or in DONE.
- abort while busy:
  - Next state is IDLE, idx=0 (vout returns to rail state immediately), counters cleared.
  - done is NOT pulsed; dig follows the normal hysteresis rule.
- One cycle period = 2*(NUM_STEPS+1) + 2*HOLD_CYCLES clocks. Run length = cycles*period + 1 (DONE).
- dig[c], registered each clk from the current vout[c]:
  - vout[c] > VTH_HI: set 1.
  - vout[c] < VTH_LO: set 0.
  - otherwise: hold.
  - Latency is one cycle after vout crosses.
- inv_mask and num_cycles changes mid-run have no effect until the next start.
- rst_n low mid-run: all outputs take reset values asynchronously; no done pulse.

Test Plan:
- Defaults, num_cycles=1, inv_mask=0, start pulse:
  - busy rises next cycle.
  - vout[0] steps 0.0, 0.18, …, 1.8 over 11 cycles, holds 5, falls 11, holds 5.
  - done pulses once at cycle 33 after start; busy low.
- Same run, check dig[0]:
  - idx 5 (0.90 V) keeps dig=0; idx 6 (1.08 V) sets dig=1 one cycle later.
  - On fall, idx 5 (0.90 V) holds 1; idx 4 (0.72 V) clears dig=0 one cycle later.
- inv_mask=4'b0101, num_cycles=3:
  - Channels 0/2 are complements of 1/3 every cycle (sum = 1.8 V ±1e-9).
  - Inverted channels' dig starts at 0 and sets to 1 one cycle after start.
  - Exactly 3 rise/fall periods (96 clocks) then one done pulse.
- num_cycles=0: behaves as 1; done exactly 33 cycles after start.
- abort during HIGH of run 2:
  - Next cycle state IDLE, vout=0.0, busy=0, no done.
  - A new start one cycle later begins a fresh run with idx=0.
- rst_n asserted low during FALL at idx=7:
  - vout=0.0, busy=0, dig=0 immediately, with no clock edge.
  - start and abort asserted together in IDLE leave busy=0.
